// File: rtl/svlib_fetch_pkg.sv
// Shared types and pointer helpers for the instruction fetch unit.
package svlib_fetch_pkg;

   localparam int unsigned FETCH_PC_W    = 32;
   localparam int unsigned FETCH_INSTR_W = 32;

   typedef struct packed {
      logic [FETCH_PC_W-1:0]    pc;
      logic [FETCH_INSTR_W-1:0] instr;
      logic                     fault;
   } fetch_entry_t;

   // Distance a - b on a w-bit wrapping pointer.
   function automatic int unsigned ptr_sub(input int unsigned a, input int unsigned b,
                                           input int unsigned w);
      return (a - b) & ((32'd1 << w) - 32'd1);
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Fetch entry ring: pc written at allocation, data/fault written at fill, read at head.
module fetch_buffer
   import svlib_fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned IW    = $clog2(DEPTH),
   localparam int unsigned CW    = IW + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     alloc_en,
   input  logic [FETCH_PC_W-1:0]    alloc_pc,
   input  logic                     fill_en,
   input  logic [FETCH_INSTR_W-1:0] fill_instr,
   input  logic                     fill_fault,
   input  logic                     pop_en,
   input  logic                     flush,
   output logic [CW-1:0]            alloc_ptr,
   output logic [CW-1:0]            fill_ptr,
   output logic [CW-1:0]            rd_ptr,
   output fetch_entry_t             head
);

   fetch_entry_t  slots [DEPTH];
   logic [IW-1:0] alloc_idx;
   logic [IW-1:0] fill_idx;
   logic [IW-1:0] rd_idx;

   // Pointers carry one extra wrap bit so a full ring differs from an empty one.
   assign alloc_idx = alloc_ptr[IW-1:0];
   assign fill_idx  = fill_ptr[IW-1:0];
   assign rd_idx    = rd_ptr[IW-1:0];
   assign head      = slots[rd_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         rd_ptr    <= '0;
      end else begin
         if (alloc_en)
            alloc_ptr <= alloc_ptr + CW'(1);
         if (flush) begin
            fill_ptr <= alloc_ptr;
            rd_ptr   <= alloc_ptr;
         end else begin
            if (fill_en)
               fill_ptr <= fill_ptr + CW'(1);
            if (pop_en)
               rd_ptr <= rd_ptr + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (alloc_en)
         slots[alloc_idx].pc <= alloc_pc;
      if (fill_en) begin
         slots[fill_idx].instr <= fill_instr;
         slots[fill_idx].fault <= fill_fault;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues PC requests to imem, tracks credits and discards, feeds decode in order.
module fetch_unit
   import svlib_fetch_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned DEPTH       = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ADDR_WIDTH-1:0]  pc_in,
   input  logic                   pc_in_valid,
   output logic                   pc_inc,
   output logic                   pc_stall,
   input  logic                   flush,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [ADDR_WIDTH-1:0]  imem_req_addr,
   input  logic                   imem_rsp_valid,
   input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
   input  logic                   imem_rsp_err,
   output logic                   dec_valid,
   input  logic                   dec_ready,
   output logic [ADDR_WIDTH-1:0]  dec_pc,
   output logic [INSTR_WIDTH-1:0] dec_instr,
   output logic                   dec_fault
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned CW = IW + 1;

   if (ADDR_WIDTH > FETCH_PC_W || INSTR_WIDTH > FETCH_INSTR_W ||
       DEPTH < 2 || DEPTH != (32'd1 << IW)) begin : g_bad_param
      $error("fetch_unit: unsupported ADDR_WIDTH/INSTR_WIDTH/DEPTH");
   end

   logic [CW-1:0] alloc_ptr;
   logic [CW-1:0] fill_ptr;
   logic [CW-1:0] rd_ptr;
   logic [CW-1:0] used;
   logic [CW-1:0] unfilled;
   logic [CW-1:0] discard;
   logic [CW-1:0] discard_nxt;
   logic          req_fire;
   logic          rsp_live;
   logic          fill_en;
   logic          pop_en;
   fetch_entry_t  head;

   assign used     = CW'(ptr_sub(32'(alloc_ptr), 32'(rd_ptr), CW));
   assign unfilled = CW'(ptr_sub(32'(alloc_ptr), 32'(fill_ptr), CW));

   // Credit check covers buffered entries plus responses still owed for flushed fetches.
   assign imem_req_valid = rst_n & pc_in_valid & ~flush & ((used + discard) < CW'(DEPTH));
   assign imem_req_addr  = pc_in;
   assign req_fire       = imem_req_valid & imem_req_ready;
   assign pc_inc         = req_fire;
   assign pc_stall       = rst_n & pc_in_valid & ~req_fire;

   assign rsp_live  = imem_rsp_valid & ((discard != '0) | (unfilled != '0));
   assign fill_en   = imem_rsp_valid & ~flush & (discard == '0) & (unfilled != '0);

   assign dec_valid = (rd_ptr != fill_ptr) & ~flush;
   assign pop_en    = dec_valid & dec_ready;
   assign dec_pc    = ADDR_WIDTH'(head.pc);
   assign dec_instr = INSTR_WIDTH'(head.instr);
   assign dec_fault = head.fault;

   // A flush turns every unfilled slot into a response to drop; one arriving now is already consumed.
   always_comb begin
      discard_nxt = discard;
      if (flush)
         discard_nxt = discard + unfilled - CW'(rsp_live);
      else if (imem_rsp_valid && discard != '0)
         discard_nxt = discard - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         discard <= '0;
      else
         discard <= discard_nxt;
   end

   fetch_buffer #(.DEPTH(DEPTH)) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .alloc_en   (req_fire),
      .alloc_pc   (FETCH_PC_W'(pc_in)),
      .fill_en    (fill_en),
      .fill_instr (FETCH_INSTR_W'(imem_rsp_data)),
      .fill_fault (imem_rsp_err),
      .pop_en     (pop_en),
      .flush      (flush),
      .alloc_ptr  (alloc_ptr),
      .fill_ptr   (fill_ptr),
      .rd_ptr     (rd_ptr),
      .head       (head)
   );

   a_no_spurious_rsp: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rsp_valid |-> rsp_live);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a variable-latency in-order memory model.
module tb_fetch_unit;

   localparam int unsigned AW    = 32;
   localparam int unsigned IW    = 32;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] pc_in;
   logic          pc_in_valid;
   logic          pc_inc;
   logic          pc_stall;
   logic          flush;
   logic          imem_req_valid;
   logic          imem_req_ready;
   logic [AW-1:0] imem_req_addr;
   logic          imem_rsp_valid;
   logic [IW-1:0] imem_rsp_data;
   logic          imem_rsp_err;
   logic          dec_valid;
   logic          dec_ready;
   logic [AW-1:0] dec_pc;
   logic [IW-1:0] dec_instr;
   logic          dec_fault;

   always #5 clk = ~clk;

   fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_in_valid(pc_in_valid),
      .pc_inc(pc_inc), .pc_stall(pc_stall), .flush(flush),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
      .dec_instr(dec_instr), .dec_fault(dec_fault)
   );

   typedef struct {
      logic [31:0] pc;
      int          due;
      bit          stale;
   } mem_t;

   mem_t        pipe[$];
   logic [31:0] exp_q[$];
   logic [31:0] pop_pc[$];
   int          pop_cyc[$];
   int          filled, stale_cnt, cyc, lat, last_due;
   int          n_checks, n_errors, n_acc;
   logic [31:0] next_pc;

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic err_of(input logic [31:0] pc);
      return (pc == 32'h40) || (pc == 32'h144);
   endfunction

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // One clock: drive at posedge+1, compare at negedge, then advance the model.
   task automatic step(input bit v, input bit fl, input bit rdy, input bit mrdy);
      bit   exp_req, exp_dv, acc, rsp_now;
      int   occ;
      mem_t rsp_ent;
      pc_in_valid    = v;
      pc_in          = next_pc;
      flush          = fl;
      dec_ready      = rdy;
      imem_req_ready = mrdy;
      rsp_now        = (pipe.size() > 0) && (pipe[0].due <= cyc);
      if (rsp_now) begin
         rsp_ent        = pipe.pop_front();
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = instr_of(rsp_ent.pc);
         imem_rsp_err   = err_of(rsp_ent.pc);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
         imem_rsp_err   = 1'b0;
      end
      @(negedge clk);
      occ     = exp_q.size() + stale_cnt;
      exp_req = v && !fl && (occ < int'(DEPTH));
      acc     = exp_req && mrdy;
      exp_dv  = (filled > 0) && !fl;
      chk("req_valid", 64'(imem_req_valid), 64'(exp_req));
      chk("pc_inc", 64'(pc_inc), 64'(acc));
      chk("pc_stall", 64'(pc_stall), 64'(v && !acc));
      if (exp_req) chk("req_addr", 64'(imem_req_addr), 64'(next_pc));
      chk("dec_valid", 64'(dec_valid), 64'(exp_dv));
      if (exp_dv) begin
         chk("dec_pc", 64'(dec_pc), 64'(exp_q[0]));
         chk("dec_instr", 64'(dec_instr), 64'(instr_of(exp_q[0])));
         chk("dec_fault", 64'(dec_fault), 64'(err_of(exp_q[0])));
      end
      if (exp_dv && rdy) begin
         pop_cyc.push_back(cyc);
         pop_pc.push_back(exp_q[0]);
         void'(exp_q.pop_front());
         filled--;
      end
      if (rsp_now) begin
         if (rsp_ent.stale) stale_cnt--;
         else               filled++;
      end
      if (acc) begin
         exp_q.push_back(next_pc);
         last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
         pipe.push_back('{pc: next_pc, due: last_due, stale: 1'b0});
         next_pc += 32'd4;
         n_acc++;
      end
      if (fl) begin
         foreach (pipe[i]) if (!pipe[i].stale) begin
            pipe[i].stale = 1'b1;
            stale_cnt++;
         end
         exp_q.delete();
         filled = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   int b, c0, a0;

   initial begin
      n_checks = 0; n_errors = 0; n_acc = 0;
      filled = 0; stale_cnt = 0; cyc = 0; lat = 1; last_due = -1;
      rst_n = 1'b0; pc_in_valid = 1'b1; pc_in = 32'h0; flush = 1'b0;
      dec_ready = 1'b1; imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
      #2;
      chk("rst_req_valid", 64'(imem_req_valid), 64'(0));
      chk("rst_pc_inc", 64'(pc_inc), 64'(0));
      chk("rst_pc_stall", 64'(pc_stall), 64'(0));
      chk("rst_dec_valid", 64'(dec_valid), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Three back-to-back fetches with a 1-cycle memory.
      lat = 1; next_pc = 32'h0; b = pop_pc.size(); c0 = cyc;
      repeat (3) step(1'b1, 1'b0, 1'b1, 1'b1);
      idle(4);
      chk("seq_npop", 64'(pop_pc.size() - b), 64'(3));
      if (pop_pc.size() >= b + 3) begin
         chk("seq_pc0", 64'(pop_pc[b]), 64'h0);
         chk("seq_pc1", 64'(pop_pc[b+1]), 64'h4);
         chk("seq_pc2", 64'(pop_pc[b+2]), 64'h8);
         chk("seq_latency", 64'(pop_cyc[b] - c0), 64'(2));
         chk("seq_consecutive", 64'(pop_cyc[b+2] - pop_cyc[b]), 64'(2));
      end

      // Decode stalled: only DEPTH requests may issue.
      next_pc = 32'h1000; a0 = n_acc;
      repeat (8) step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("full_accepts", 64'(n_acc - a0), 64'(DEPTH));
      chk("full_stall", 64'(pc_stall), 64'(1));
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      chk("full_resume", 64'(n_acc - a0), 64'(DEPTH + 1));
      idle(8);

      // Access fault is carried to decode.
      next_pc = 32'h40; b = pop_pc.size();
      step(1'b1, 1'b0, 1'b1, 1'b1);
      idle(3);
      chk("fault_npop", 64'(pop_pc.size() - b), 64'(1));

      // Flush with two requests in flight; their responses must be dropped.
      lat = 3; next_pc = 32'h200;
      repeat (2) step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      next_pc = 32'h100; b = pop_pc.size();
      step(1'b1, 1'b0, 1'b1, 1'b1);
      idle(7);
      chk("flush_npop", 64'(pop_pc.size() - b), 64'(1));
      if (pop_pc.size() > b) chk("flush_first_pc", 64'(pop_pc[b]), 64'h100);

      // Flush in the same cycle as a response and dec_ready.
      lat = 2; next_pc = 32'h300;
      repeat (3) step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      next_pc = 32'h400; b = pop_pc.size();
      step(1'b1, 1'b0, 1'b1, 1'b1);
      idle(6);
      chk("flush_rsp_npop", 64'(pop_pc.size() - b), 64'(1));
      if (pop_pc.size() > b) chk("flush_rsp_pc", 64'(pop_pc[b]), 64'h400);

      // Mixed traffic with back-pressure and occasional flushes.
      next_pc = 32'h140;
      for (int i = 0; i < 80; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
      idle(8);

      // Asynchronous reset with three entries buffered.
      lat = 1; next_pc = 32'h500;
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
      repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("areset_pre_valid", 64'(dec_valid), 64'(1));
      pc_in_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset_dec_valid", 64'(dec_valid), 64'(0));
      chk("areset_req_valid", 64'(imem_req_valid), 64'(0));
      chk("areset_pc_stall", 64'(pc_stall), 64'(0));
      exp_q.delete(); pipe.delete();
      filled = 0; stale_cnt = 0; last_due = -1;
      imem_rsp_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      next_pc = 32'h600; b = pop_pc.size();
      step(1'b1, 1'b0, 1'b1, 1'b1);
      idle(3);
      chk("areset_after_npop", 64'(pop_pc.size() - b), 64'(1));
      if (pop_pc.size() > b) chk("areset_after_pc", 64'(pop_pc[b]), 64'h600);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
